// File: rtl/stage3_mem_wb.sv
// stage3_mem_wb: stage-3 memory/writeback block of the three-stage RV32I pipeline.
// Registers the stage-2 result and runs loads and stores over a valid/ready
// request port with a separate response port. Load data is aligned and extended
// before it reaches the register-file write port. Memory operations hold the
// pipeline through the global stall line until they complete.
module stage3_mem_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_pc4,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic        in_reg_we,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [4:0]  rd,
  output logic [31:0] wb_data,
  output logic        we,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Access-size encodings of funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Writeback source encodings (3 falls back to the ALU)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // FSM and registered handshake/stall outputs
  state_t      state_q;
  logic        req_valid_q;
  logic        stall_q;

  // Held instruction (input register)
  logic        held_valid_q;
  logic [31:0] held_alu_q;
  logic [31:0] held_sdata_q;
  logic [31:0] held_pc4_q;
  logic [2:0]  held_funct3_q;
  logic        held_is_load_q;
  logic        held_is_store_q;
  logic        held_reg_we_q;
  logic [4:0]  held_rd_q;
  logic [1:0]  held_wb_sel_q;

  // Load word latched from the response port
  logic [31:0] load_q;

  // Combinational helpers
  logic        capture_s;
  logic        in_mem_op_s;
  logic [3:0]  wmask_s;
  logic [31:0] load_ext_s;
  logic [31:0] wb_src_s;
  logic        retire_ok_s;
  logic        we_s;

  // Byte enables of a store; the size comes from funct3[1:0].
  // A halfword ignores addr[0] and a word ignores addr[1:0].
  function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << addr_lo;
      2'b01:   mask = 4'b0011 << {addr_lo[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Store data replicated across lanes so the mask alone selects the bytes
  function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                             input logic [31:0] data);
    logic [31:0] wdata;
    case (funct3[1:0])
      2'b00:   wdata = {4{data[7:0]}};
      2'b01:   wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

  // Select the addressed byte/halfword of a load word and extend it
  function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (addr_lo[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, byte_v};
      F3_HU:   result = {16'd0, half_v};
      default: result = word;
    endcase
    return result;
  endfunction

  // The input register loads whenever the pipeline is not stalled
  assign capture_s   = ~stall_q;
  assign in_mem_op_s = in_valid & (in_is_load | in_is_store);

  // Input register: holds the instruction while a memory op is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid_q    <= 1'b0;
      held_alu_q      <= 32'd0;
      held_sdata_q    <= 32'd0;
      held_pc4_q      <= 32'd0;
      held_funct3_q   <= 3'd0;
      held_is_load_q  <= 1'b0;
      held_is_store_q <= 1'b0;
      held_reg_we_q   <= 1'b0;
      held_rd_q       <= 5'd0;
      held_wb_sel_q   <= 2'd0;
    end else if (capture_s) begin
      held_valid_q    <= in_valid;
      held_alu_q      <= in_alu;
      held_sdata_q    <= in_store_data;
      held_pc4_q      <= in_pc4;
      held_funct3_q   <= in_funct3;
      held_is_load_q  <= in_is_load;
      held_is_store_q <= in_is_store;
      held_reg_we_q   <= in_reg_we;
      held_rd_q       <= in_rd;
      held_wb_sel_q   <= in_wb_sel;
    end
  end

  // Memory FSM; request valid and stall are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      load_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Capture edge: a valid memory op starts a request at once
          if (in_mem_op_s) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            stall_q     <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            stall_q     <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (held_is_load_q) begin
              state_q <= S_WAIT;
              stall_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              stall_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // Responses are only honoured here; elsewhere they are dropped
          if (mem_resp_valid) begin
            load_q  <= mem_resp_data;
            state_q <= S_DONE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  // Byte enables are only presented while a store request is pending
  always_comb begin
    wmask_s = 4'b0000;
    if ((state_q == S_REQ) && held_is_store_q) begin
      wmask_s = store_mask(held_funct3_q, held_alu_q[1:0]);
    end else begin
      wmask_s = 4'b0000;
    end
  end

  // Writeback source select
  always_comb begin
    load_ext_s = load_extract(held_funct3_q, held_alu_q[1:0], load_q);
    case (held_wb_sel_q)
      WB_ALU:  wb_src_s = held_alu_q;
      WB_MEM:  wb_src_s = load_ext_s;
      WB_PC4:  wb_src_s = held_pc4_q;
      default: wb_src_s = held_alu_q;
    endcase
  end

  // Retire qualification: loads only in DONE, stores never, others when held
  always_comb begin
    retire_ok_s = 1'b0;
    if (held_is_store_q) begin
      retire_ok_s = 1'b0;
    end else if (held_is_load_q) begin
      retire_ok_s = (state_q == S_DONE);
    end else begin
      retire_ok_s = 1'b1;
    end
    we_s = held_valid_q & held_reg_we_q & (held_rd_q != 5'd0) & ~stall_q & retire_ok_s;
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = held_alu_q[31:2];
  assign mem_req_wdata = store_data(held_funct3_q, held_sdata_q);
  assign mem_req_wmask = wmask_s;
  assign stall         = stall_q;
  assign we            = we_s;
  assign rd            = held_rd_q;
  assign wb_data       = we_s ? wb_src_s : 32'd0;

endmodule

// File: tb/tb_stage3_mem_wb.sv
// Directed testbench for stage3_mem_wb with hand-computed expected values.
module tb_stage3_mem_wb;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu;
  logic [31:0] in_store_data;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_reg_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        we;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  stage3_mem_wb dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_alu         (in_alu),
    .in_store_data  (in_store_data),
    .in_pc4         (in_pc4),
    .in_funct3      (in_funct3),
    .in_is_load     (in_is_load),
    .in_is_store    (in_is_store),
    .in_reg_we      (in_reg_we),
    .in_rd          (in_rd),
    .in_wb_sel      (in_wb_sel),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .rd             (rd),
    .wb_data        (wb_data),
    .we             (we),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [31:0] pc4, input logic [2:0] f3, input logic ld,
                       input logic st, input logic rwe, input logic [4:0] rdi,
                       input logic [1:0] wbs);
    in_valid      = v;
    in_alu        = alu;
    in_store_data = sdata;
    in_pc4        = pc4;
    in_funct3     = f3;
    in_is_load    = ld;
    in_is_store   = st;
    in_reg_we     = rwe;
    in_rd         = rdi;
    in_wb_sel     = wbs;
  endtask

  task automatic bubble();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    bubble();
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_reqv", {31'd0, mem_req_valid}, 32'd0);
    check("rst_wmask", {28'd0, mem_req_wmask}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    reset = 1'b0;

    // ADD x5 = 0x1234
    drive(1'b1, 32'h0000_1234, 32'd0, 32'h0000_0010, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd0);
    tick();
    check("add_we", {31'd0, we}, 32'd1);
    check("add_rd", {27'd0, rd}, 32'd5);
    check("add_wb", wb_data, 32'h0000_1234);
    check("add_stall", {31'd0, stall}, 32'd0);
    bubble();
    tick();
    check("bub_we", {31'd0, we}, 32'd0);
    check("bub_wb", wb_data, 32'd0);

    // JAL x1: writes PC+4
    drive(1'b1, 32'h0000_0800, 32'd0, 32'h0000_0104, 3'd0, 1'b0, 1'b0, 1'b1, 5'd1, 2'd2);
    tick();
    check("jal_wb", wb_data, 32'h0000_0104);
    check("jal_stall", {31'd0, stall}, 32'd0);

    // LB x6 from 0x103, response arrives two cycles after acceptance
    mem_req_ready = 1'b1;
    drive(1'b1, 32'h0000_0103, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'd1);
    tick();
    check("lb_reqv", {31'd0, mem_req_valid}, 32'd1);
    check("lb_addr", {2'd0, mem_req_addr}, 32'h0000_0040);
    check("lb_mask", {28'd0, mem_req_wmask}, 32'd0);
    check("lb_stall1", {31'd0, stall}, 32'd1);
    check("lb_we_req", {31'd0, we}, 32'd0);
    bubble();
    tick();
    mem_req_ready = 1'b0;
    check("lb_stall2", {31'd0, stall}, 32'd1);
    check("lb_reqv_wait", {31'd0, mem_req_valid}, 32'd0);
    tick();
    check("lb_stall3", {31'd0, stall}, 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h80FF_0000;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    check("lb_done_stall", {31'd0, stall}, 32'd0);
    check("lb_we", {31'd0, we}, 32'd1);
    check("lb_rd", {27'd0, rd}, 32'd6);
    check("lb_wb", wb_data, 32'hFFFF_FF80);
    tick();
    check("lb_after_we", {31'd0, we}, 32'd0);

    // SH at 0x202, data 0xBEEF, ready low for two cycles
    drive(1'b1, 32'h0000_0202, 32'h0000_BEEF, 32'd0, 3'd1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    tick();
    bubble();
    for (int i = 0; i < 2; i++) begin
      check("sh_reqv", {31'd0, mem_req_valid}, 32'd1);
      check("sh_addr", {2'd0, mem_req_addr}, 32'h0000_0080);
      check("sh_mask", {28'd0, mem_req_wmask}, 32'h0000_000C);
      check("sh_wdata", mem_req_wdata, 32'hBEEF_BEEF);
      check("sh_stall", {31'd0, stall}, 32'd1);
      check("sh_we", {31'd0, we}, 32'd0);
      tick();
    end
    check("sh_reqv3", {31'd0, mem_req_valid}, 32'd1);
    check("sh_mask3", {28'd0, mem_req_wmask}, 32'h0000_000C);
    mem_req_ready = 1'b1;
    tick();
    check("sh_done_stall", {31'd0, stall}, 32'd0);
    check("sh_done_reqv", {31'd0, mem_req_valid}, 32'd0);
    check("sh_done_mask", {28'd0, mem_req_wmask}, 32'd0);
    check("sh_done_we", {31'd0, we}, 32'd0);

    // SB at 0x101, data 0x12345678 (captured on the DONE edge)
    drive(1'b1, 32'h0000_0101, 32'h1234_5678, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    tick();
    bubble();
    check("sb_reqv", {31'd0, mem_req_valid}, 32'd1);
    check("sb_mask", {28'd0, mem_req_wmask}, 32'h0000_0002);
    check("sb_wdata", mem_req_wdata, 32'h7878_7878);
    tick();
    check("sb_done_stall", {31'd0, stall}, 32'd0);
    tick();

    // LHU x7 at 0x4, then LW x8 at 0x8 back to back
    drive(1'b1, 32'h0000_0004, 32'd0, 32'd0, 3'd5, 1'b1, 1'b0, 1'b1, 5'd7, 2'd1);
    tick();
    check("lhu_addr", {2'd0, mem_req_addr}, 32'h0000_0001);
    drive(1'b1, 32'h0000_0008, 32'd0, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd8, 2'd1);
    tick();
    check("lhu_wait_stall", {31'd0, stall}, 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_8001;
    tick();
    mem_resp_valid = 1'b0;
    check("lhu_we", {31'd0, we}, 32'd1);
    check("lhu_rd", {27'd0, rd}, 32'd7);
    check("lhu_wb", wb_data, 32'h0000_8001);
    tick();
    bubble();
    check("lw_reqv", {31'd0, mem_req_valid}, 32'd1);
    check("lw_addr", {2'd0, mem_req_addr}, 32'h0000_0002);
    check("lw_stall", {31'd0, stall}, 32'd1);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    tick();
    mem_resp_valid = 1'b0;
    check("lw_rd", {27'd0, rd}, 32'd8);
    check("lw_wb", wb_data, 32'hCAFE_F00D);
    tick();

    // Load to x0: full handshake, no write
    drive(1'b1, 32'h0000_0010, 32'd0, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd0, 2'd1);
    tick();
    bubble();
    check("x0_reqv", {31'd0, mem_req_valid}, 32'd1);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1111_2222;
    tick();
    mem_resp_valid = 1'b0;
    check("x0_stall", {31'd0, stall}, 32'd0);
    check("x0_we", {31'd0, we}, 32'd0);
    check("x0_wb", wb_data, 32'd0);
    tick();

    // Reset while waiting for the response; the late response is dropped
    drive(1'b1, 32'h0000_0020, 32'd0, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd9, 2'd1);
    tick();
    bubble();
    tick();
    check("rw_stall_wait", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_stall", {31'd0, stall}, 32'd0);
    check("rw_reqv", {31'd0, mem_req_valid}, 32'd0);
    check("rw_we", {31'd0, we}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    check("rw_stray_we", {31'd0, we}, 32'd0);
    check("rw_stray_stall", {31'd0, stall}, 32'd0);
    drive(1'b1, 32'h0000_0055, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd10, 2'd0);
    tick();
    bubble();
    check("rw_add_we", {31'd0, we}, 32'd1);
    check("rw_add_rd", {27'd0, rd}, 32'd10);
    check("rw_add_wb", wb_data, 32'h0000_0055);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage3_mem_wb.md
# stage3_mem_wb

Stage-3 memory/writeback block of the three-stage RV32I pipeline. It registers the stage-2 result, performs loads and stores through a valid/ready request port with a separate response port, and aligns and extends load data. It drives the register-file write port (`rd`, `wb_data`, `we`) and the global `stall` line, which also gates register-file writes. ALU and jump results retire in one cycle; memory operations hold the pipeline until they complete.

## Interface
- Parameters: none. Data is 32-bit, and the memory address is a 30-bit word address.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  a stage-2 instruction is present
- `in_alu`  in  32  ALU result; this is the effective address for loads and stores
- `in_store_data`  in  32  rs2 data for stores
- `in_pc4`  in  32  PC+4 of the instruction
- `in_funct3`  in  3  access size/sign: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
- `in_is_load`, `in_is_store`  in  1 each  memory op type; the two are mutually exclusive
- `in_reg_we`  in  1  instruction writes rd
- `in_rd`  in  5  destination register
- `in_wb_sel`  in  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4 (3 is treated as 0)
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_addr`  out  30  `in_alu[31:2]` of the held instruction
- `mem_req_wdata`  out  32  lane-replicated store data
- `mem_req_wmask`  out  4  byte enables; 0 means read
- `mem_resp_valid`  in  1  load data valid
- `mem_resp_data`  in  32  load word
- `rd`  out  5  write index to the register file
- `wb_data`  out  32  write data
- `we`  out  1  write enable
- `stall`  out  1  freezes stages 1–2, the register file, and this block's input register

## Operation
- **Input register.** It captures all `in_*` signals on each clock where `stall` = 0. Bubbles are captured with `in_valid` = 0.
- **FSM states**
  - IDLE. The held instruction is a non-memory op or a bubble.
  - REQ. `mem_req_valid` = 1.
  - WAIT. Awaiting `mem_resp_valid`.
  - DONE. The memory op retires.
- **FSM transitions**
  - From IDLE or DONE, while capturing: a valid load or store goes to REQ; anything else goes to IDLE.
  - REQ with `mem_req_ready` = 1: a load goes to WAIT, a store goes to DONE.
  - WAIT with `mem_resp_valid` = 1: latch `mem_resp_data`, then go to DONE.
- **stall** = 1 in REQ and WAIT, 0 otherwise.
- **Store masks and data**
  - SB: mask is `4'b0001 << addr[1:0]`, and the data byte is replicated to all four lanes.
  - SH: mask is `4'b0011 << {addr[1], 0}`, and the halfword is replicated to both halves.
  - SW: mask is `4'b1111`.
  - Loads: mask is `4'b0000`.
- **Misaligned accesses.** A misaligned halfword ignores `addr[0]`. A misaligned word ignores `addr[1:0]`. No trap is raised.
- **Load extract.** The byte or halfword is selected from the latched word by `addr[1:0]`, then sign-extended (B, H) or zero-extended (BU, HU).
- **Writeback source** follows `wb_sel`: ALU, extracted load data, or PC+4.
- **we** = `held_valid` & `reg_we` & (`rd` != 0) & ~`stall`. Stores never write. When `we` = 0, `wb_data` is driven to 0.
- **Retire state.** A load retires (`we` asserted) only in DONE. Non-memory ops retire in the cycle they are held in IDLE.
- **Stray responses.** `mem_resp_valid` is ignored outside WAIT.
- **Reset** sets state to IDLE and `held_valid` to 0. Reset values: `mem_req_valid` 0, `mem_req_wmask` 0, `we` 0, `stall` 0, `wb_data` 0, `rd` 0.

## Timing
- **ALU / JAL latency.** Writeback occurs the cycle after capture, with zero stall cycles.
- **Load latency.** Capture at edge N. REQ in N+1. With ready = 1 and a response 1 cycle later: WAIT in N+2, DONE in N+3, writeback committed at edge N+4. Stall cycles = 1 + req wait + resp wait + 1 (WAIT entry), which is a minimum of 2.
- **Store latency.** REQ followed by DONE, for a minimum of 1 stall cycle.
- **Request hold.** Once asserted, `mem_req_valid`, `mem_req_addr`, `mem_req_wdata`, and `mem_req_wmask` stay stable until the cycle ready is sampled high.
- **Back-to-back.** DONE captures the next instruction on the same edge that commits the current writeback. A following memory op therefore re-enters REQ with no idle cycle.
- **Reset mid-transaction.** Reset asserted in REQ or WAIT causes `mem_req_valid` and `stall` to be low from the next cycle. Any later response is dropped and no writeback occurs.
- **Single outstanding request.** At most one request is outstanding. Memory must not return a response before accepting the request.

## Test plan
- **ADD x5.** Result 0x1234, `wb_sel` = 0. Expect `we` = 1, `rd` = 5, `wb_data` = 0x1234 one cycle after capture, with `stall` = 0 throughout.
- **LB x6, addr 0x103.** Ready immediate, response 0x80FF_0000 two cycles later. Expect `mem_req_addr` = 0x40, mask 0, `stall` high for 3 cycles, and `wb_data` = 0xFFFF_FF80 in DONE.
- **SH at 0x202, data 0x0000_BEEF.** Ready held low for 2 cycles. Expect mask 0b1100, wdata 0xBEEF_BEEF, and request fields stable during the wait. `we` stays 0.
- **LHU at 0x4, then LW immediately.** Second instruction is held. Response to the first is 0x0000_8001. Expect `wb_data` 0x8001 zero-extended, and the LW request issued the cycle after DONE.
- **Load to x0.** Expect a full handshake with `we` = 0 in DONE.
- **Reset in WAIT, then response arrives.** Expect `stall` 0, `mem_req_valid` 0, and no `we` pulse. The next ADD retires normally.
